conv1x1_fetch_sequencer: RTL and testbench
==========================================

# conv1x1_fetch_sequencer

Parametrised address and lane-control sequencer for the 1x1 convolution engine. For each output pixel it walks every filter group (NUM_PE filters) and every channel chunk (WORD_BYTES channels), issuing IFM/weight fetch addresses with a valid/ready handshake. It also drives per-lane PE enable and accumulate-finish strobes. It sits between the layer-configuration registers and the IFM/weight SRAM read ports feeding the PE array.

## Interface
- ADDR_W, 32, address width (byte addresses)
- CNT_W, 16, width of channel/filter/pixel counts
- NUM_PE, 4, PE lanes; filters per group
- WORD_BYTES, 4, channels per fetch beat (power of two)
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle start pulse; ignored unless idle
- abort  in  1  synchronous cancel; returns to IDLE, no done
- cfg_channels  in  CNT_W  input channels C
- cfg_filters  in  CNT_W  filter count F
- cfg_pixels  in  CNT_W  output pixel count P
- ifm_base, wgt_base  in  ADDR_W  base byte addresses
- fetch_ready  in  1  memory accepts current beat
- fetch_valid  out  1  beat valid
- addr_ifm, addr_weight  out  ADDR_W  beat addresses
- pe_en  out  NUM_PE  active lanes for this beat
- pe_finish  out  NUM_PE  last-chunk strobe per active lane
- busy  out  1  high from LOAD until return to IDLE
- done  out  1  one-cycle completion pulse

## Operation
- K = ceil(C/WORD_BYTES) chunks per pixel; G = ceil(F/NUM_PE) groups. Partial chunks are zero-padded in memory and need no masking.
- Loop order: pixel p (outer), group g, chunk c (inner).
- Beat addresses:
  - addr_ifm = ifm_base + (p*K + c)*WORD_BYTES. The IFM rewinds to the pixel start at each new group.
  - addr_weight = wgt_base + (g*K + c)*WORD_BYTES. The weight address restarts at wgt_base at each new pixel.
- Offsets use incremental adders/accumulators; no multipliers.
- pe_en: lane i is high iff g*NUM_PE + i < F, and only while fetch_valid. Last group may be partial.
- pe_finish = pe_en on beat c = K-1, else 0.
- FSM:
  - IDLE: on start, latch cfg and bases -> LOAD.
  - LOAD: compute K, G. If C, F or P is 0 -> DONE; else -> FETCH.
  - FETCH: a beat advances only on fetch_valid && fetch_ready. When the final beat (p=P-1, g=G-1, c=K-1) is accepted -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- abort in any non-IDLE state: next cycle IDLE, all outputs 0, no done; abort in IDLE has no effect.
- start while busy: ignored. start and abort in the same IDLE cycle: abort wins.
- Arithmetic wraps modulo 2^ADDR_W. Internal counters are CNT_W bits; K and G are computed in CNT_W+1 bits to avoid overflow.

## Timing
- Reset: all outputs 0, FSM IDLE, counters 0.
- All outputs registered.
- Latency: start at cycle t -> LOAD at t+1 -> first fetch_valid at t+2.
- Handshake:
  - fetch_valid, addresses, pe_en and pe_finish hold stable while fetch_valid && !fetch_ready.
  - Once asserted, fetch_valid never drops before acceptance, except on abort or reset.
- Throughput: one beat per cycle with fetch_ready held high; no bubbles at chunk, group or pixel boundaries.
- done asserts the cycle after the final beat is accepted; fetch_valid is 0 in that cycle.
- Zero-size config: done at t+2, no beats.
- Reset mid-operation: immediate return to reset values.

## Structure
- Package conv_pkg: state enum (IDLE, LOAD, FETCH, DONE) and a ceil-divide-by-power-of-two function.
- Sub-module conv_loop_counter: a nested counter with wrap and carry-out, instantiated for the chunk, group and pixel levels.
- Address accumulators and lane-mask logic stay in the top module.

## Test plan
- C=8, F=4, P=2, ready=1 -> 4 beats:
  - ifm 0,4,8,12; weight 0,4,0,4.
  - pe_en 4'b1111 on every beat; pe_finish 4'b1111 on beats 2 and 4.
  - done one cycle after beat 4.
- C=8, F=6, P=1 -> beats ifm 0,4,0,4; weight 0,4,8,12; pe_en 1111,1111,0011,0011; pe_finish on beats 2 (1111) and 4 (0011).
- C=6, F=4, P=1, ifm_base=0x100, wgt_base=0x200 -> K=2; ifm 0x100,0x104; weight 0x200,0x204.
- C=8, F=4, P=2 with fetch_ready low for 3 cycles on beat 2 -> beat 2 outputs held unchanged across the stall; total 4 accepted beats; done timing shifted by 3 cycles.
- cfg_pixels=0 -> no fetch_valid, done at start+2. A start pulse during FETCH -> ignored, sequence unaltered.
- abort in FETCH at beat 3 -> next cycle all outputs 0, no done. A fresh start then reruns from beat 1. A reset_n pulse mid-run gives the same result.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the 1x1 convolution fetch sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package conv_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ceil(x / 2^lg); the sum is one bit wider so x near full scale cannot overflow
    function automatic logic [31:0] ceil_div_pow2(input logic [31:0] x, input int unsigned lg);
        logic [32:0] sum;
        sum = {1'b0, x} + ((33'd1 << lg) - 33'd1);
        return 32'(sum >> lg);
    endfunction

endpackage

// File: rtl/conv_loop_counter.sv
// One level of a nested loop counter: counts 0..max_i, wraps, and flags carry-out.
// Latency: count updates on the clock edge after inc_i; last_o/carry_o are combinational.
// Backpressure: advances only when inc_i is high; clear_i has priority over inc_i.
module conv_loop_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear_i,
    input  logic         inc_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o,
    output logic         carry_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign last_o  = (cnt_q == max_i);
    assign carry_o = inc_i && last_o;
    assign cnt_o   = cnt_q;

    // Next count: clear, wrap at max, or step
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last_o ? '0 : cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv1x1_fetch_sequencer.sv
// Walks pixel/group/chunk loops issuing IFM and weight fetch addresses plus PE lane strobes.
// Latency: start -> first fetch_valid in 2 cycles; done 1 cycle after the final accepted beat.
// Backpressure: beat outputs hold while fetch_valid && !fetch_ready; one beat per cycle otherwise.
module conv1x1_fetch_sequencer
    import conv_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16,
    parameter int NUM_PE     = 4,   // power of two: group count uses a shift-based ceil divide
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_channels,
    input  logic [CNT_W-1:0]  cfg_filters,
    input  logic [CNT_W-1:0]  cfg_pixels,
    input  logic [ADDR_W-1:0] ifm_base,
    input  logic [ADDR_W-1:0] wgt_base,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] addr_ifm,
    output logic [ADDR_W-1:0] addr_weight,
    output logic [NUM_PE-1:0] pe_en,
    output logic [NUM_PE-1:0] pe_finish,
    output logic              busy,
    output logic              done
);

    localparam int KW    = CNT_W + 1;
    localparam int WB_LG = $clog2(WORD_BYTES);
    localparam int PE_LG = $clog2(NUM_PE);
    localparam logic [ADDR_W-1:0] WB_STEP = ADDR_W'(WORD_BYTES);
    localparam logic [KW-1:0]     PE_STEP = KW'(NUM_PE);

    state_t state_q, state_d;

    // Latched configuration and derived loop bounds
    logic [CNT_W-1:0]  c_q, c_d, f_q, f_d, p_q, p_d;
    logic [ADDR_W-1:0] ifm_base_q, ifm_base_d, wgt_base_q, wgt_base_d;
    logic [KW-1:0]     k_q, k_d, g_q, g_d;
    logic [KW-1:0]     k_calc, g_calc;

    // Address accumulators: start of current pixel in IFM, filters left from current group
    logic [ADDR_W-1:0] pix_base_q, pix_base_d;
    logic [KW-1:0]     rem_q, rem_d;

    // Registered beat outputs
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] ifm_q, ifm_d, wgt_q, wgt_d;
    logic [NUM_PE-1:0] en_q, en_d, fin_q, fin_d;
    logic              busy_q, busy_d, done_q, done_d;

    // Loop counters
    logic             cnt_clear, accept;
    logic [CNT_W-1:0] chunk_max, grp_max, pix_max;
    logic [CNT_W-1:0] chunk_cnt, grp_cnt_unused, pix_cnt_unused;
    logic             chunk_last, chunk_carry, grp_last, grp_carry, pix_last_unused, final_beat;
    logic             new_beat, nxt_fin;

    assign k_calc = KW'(ceil_div_pow2(32'(c_q), WB_LG));
    assign g_calc = KW'(ceil_div_pow2(32'(f_q), PE_LG));

    assign cnt_clear = (state_q != FETCH);
    assign accept    = valid_q && fetch_ready;
    assign chunk_max = CNT_W'(k_q - KW'(1));
    assign grp_max   = CNT_W'(g_q - KW'(1));
    assign pix_max   = p_q - CNT_W'(1);

    conv_loop_counter #(.W(CNT_W)) u_chunk (
        .clk(clk), .reset_n(reset_n), .clear_i(cnt_clear), .inc_i(accept),
        .max_i(chunk_max), .cnt_o(chunk_cnt), .last_o(chunk_last), .carry_o(chunk_carry)
    );

    conv_loop_counter #(.W(CNT_W)) u_group (
        .clk(clk), .reset_n(reset_n), .clear_i(cnt_clear), .inc_i(chunk_carry),
        .max_i(grp_max), .cnt_o(grp_cnt_unused), .last_o(grp_last), .carry_o(grp_carry)
    );

    conv_loop_counter #(.W(CNT_W)) u_pixel (
        .clk(clk), .reset_n(reset_n), .clear_i(cnt_clear), .inc_i(grp_carry),
        .max_i(pix_max), .cnt_o(pix_cnt_unused), .last_o(pix_last_unused), .carry_o(final_beat)
    );

    // Lane i is live while at least i+1 filters remain in the current group
    function automatic logic [NUM_PE-1:0] lane_mask(input logic [KW-1:0] rem);
        logic [NUM_PE-1:0] m;
        for (int i = 0; i < NUM_PE; i++) begin
            m[i] = (rem > KW'(i));
        end
        return m;
    endfunction

    // Next-state, next-beat address/lane computation, abort override
    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        f_d        = f_q;
        p_d        = p_q;
        ifm_base_d = ifm_base_q;
        wgt_base_d = wgt_base_q;
        k_d        = k_q;
        g_d        = g_q;
        pix_base_d = pix_base_q;
        rem_d      = rem_q;
        valid_d    = 1'b0;
        ifm_d      = '0;
        wgt_d      = '0;
        en_d       = '0;
        fin_d      = '0;
        new_beat   = 1'b0;
        nxt_fin    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = LOAD;
                    c_d        = cfg_channels;
                    f_d        = cfg_filters;
                    p_d        = cfg_pixels;
                    ifm_base_d = ifm_base;
                    wgt_base_d = wgt_base;
                end
            end
            LOAD: begin
                k_d = k_calc;
                g_d = g_calc;
                if (c_q == '0 || f_q == '0 || p_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d    = FETCH;
                    new_beat   = 1'b1;
                    ifm_d      = ifm_base_q;
                    pix_base_d = ifm_base_q;
                    wgt_d      = wgt_base_q;
                    rem_d      = {1'b0, f_q};
                    nxt_fin    = (k_calc == KW'(1));
                end
            end
            FETCH: begin
                if (!accept) begin
                    valid_d = valid_q;
                    ifm_d   = ifm_q;
                    wgt_d   = wgt_q;
                    en_d    = en_q;
                    fin_d   = fin_q;
                end else if (final_beat) begin
                    state_d = DONE;
                end else begin
                    new_beat = 1'b1;
                    if (!chunk_last) begin
                        // next chunk of the same pixel and group
                        ifm_d   = ifm_q + WB_STEP;
                        wgt_d   = wgt_q + WB_STEP;
                        nxt_fin = (({1'b0, chunk_cnt} + KW'(2)) == k_q);
                    end else if (!grp_last) begin
                        // next filter group: rewind IFM, weights run on contiguously
                        ifm_d   = pix_base_q;
                        wgt_d   = wgt_q + WB_STEP;
                        rem_d   = rem_q - PE_STEP;
                        nxt_fin = (k_q == KW'(1));
                    end else begin
                        // next pixel: IFM continues past this pixel, weights restart
                        ifm_d      = ifm_q + WB_STEP;
                        pix_base_d = ifm_q + WB_STEP;
                        wgt_d      = wgt_base_q;
                        rem_d      = {1'b0, f_q};
                        nxt_fin    = (k_q == KW'(1));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (new_beat) begin
            valid_d = 1'b1;
            en_d    = lane_mask(rem_d);
            fin_d   = nxt_fin ? en_d : '0;
        end

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ifm_d   = '0;
            wgt_d   = '0;
            en_d    = '0;
            fin_d   = '0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, configuration and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            c_q        <= '0;
            f_q        <= '0;
            p_q        <= '0;
            ifm_base_q <= '0;
            wgt_base_q <= '0;
            k_q        <= '0;
            g_q        <= '0;
            pix_base_q <= '0;
            rem_q      <= '0;
            valid_q    <= 1'b0;
            ifm_q      <= '0;
            wgt_q      <= '0;
            en_q       <= '0;
            fin_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            f_q        <= f_d;
            p_q        <= p_d;
            ifm_base_q <= ifm_base_d;
            wgt_base_q <= wgt_base_d;
            k_q        <= k_d;
            g_q        <= g_d;
            pix_base_q <= pix_base_d;
            rem_q      <= rem_d;
            valid_q    <= valid_d;
            ifm_q      <= ifm_d;
            wgt_q      <= wgt_d;
            en_q       <= en_d;
            fin_q      <= fin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fetch_valid = valid_q;
    assign addr_ifm    = ifm_q;
    assign addr_weight = wgt_q;
    assign pe_en       = en_q;
    assign pe_finish   = fin_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_conv1x1_fetch_sequencer.sv
// Self-checking bench for conv1x1_fetch_sequencer: table of configurations plus scoreboard.
// Latency: expects first beat at start+2 and done at start+2+beats+stall cycles.
// Backpressure: drives fetch_ready low for scripted stall cycles and checks beats hold.
`timescale 1ns/1ps
module tb_conv1x1_fetch_sequencer;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;
    localparam int NUM_PE = 4;
    localparam int WB     = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W-1:0]  cfg_channels = '0;
    logic [CNT_W-1:0]  cfg_filters = '0;
    logic [CNT_W-1:0]  cfg_pixels = '0;
    logic [ADDR_W-1:0] ifm_base = '0;
    logic [ADDR_W-1:0] wgt_base = '0;
    logic              fetch_ready = 1'b1;
    logic              fetch_valid;
    logic [ADDR_W-1:0] addr_ifm;
    logic [ADDR_W-1:0] addr_weight;
    logic [NUM_PE-1:0] pe_en;
    logic [NUM_PE-1:0] pe_finish;
    logic              busy;
    logic              done;

    conv1x1_fetch_sequencer #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .NUM_PE(NUM_PE), .WORD_BYTES(WB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_channels(cfg_channels), .cfg_filters(cfg_filters), .cfg_pixels(cfg_pixels),
        .ifm_base(ifm_base), .wgt_base(wgt_base), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .addr_ifm(addr_ifm), .addr_weight(addr_weight),
        .pe_en(pe_en), .pe_finish(pe_finish), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CNT_W-1:0]  c, f, p;
        logic [ADDR_W-1:0] ib, wb;
        int                stall_beat, stall_len, poke_beat, exp_beats;
        logic [ADDR_W-1:0] last_ifm, last_wgt;
        logic [NUM_PE-1:0] last_en, last_fin;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] ifm, wgt;
        logic [NUM_PE-1:0] en, fin;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input int c, f, p, input logic [31:0] ib, wb,
                                input int sb, sl, pk, nb,
                                input logic [31:0] li, lw, input logic [3:0] le, lf);
        vec_t v;
        v.c = CNT_W'(c); v.f = CNT_W'(f); v.p = CNT_W'(p);
        v.ib = ib; v.wb = wb;
        v.stall_beat = sb; v.stall_len = sl; v.poke_beat = pk; v.exp_beats = nb;
        v.last_ifm = li; v.last_wgt = lw; v.last_en = le; v.last_fin = lf;
        return v;
    endfunction

    // Reference beat list straight from the address formulas
    task automatic model_push(input vec_t v);
        int k, g;
        beat_t b;
        k = (int'(v.c) + WB - 1) / WB;
        g = (int'(v.f) + NUM_PE - 1) / NUM_PE;
        for (int p = 0; p < int'(v.p); p++)
            for (int gi = 0; gi < g; gi++)
                for (int ci = 0; ci < k; ci++) begin
                    b.ifm = v.ib + 32'((p * k + ci) * WB);
                    b.wgt = v.wb + 32'((gi * k + ci) * WB);
                    for (int i = 0; i < NUM_PE; i++) b.en[i] = (gi * NUM_PE + i < int'(v.f));
                    b.fin = (ci == k - 1) ? b.en : '0;
                    exp_q.push_back(b);
                end
    endtask

    task automatic load_cfg(input vec_t v);
        cfg_channels = v.c; cfg_filters = v.f; cfg_pixels = v.p;
        ifm_base = v.ib; wgt_base = v.wb;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_addr"}, {addr_ifm, addr_weight}, 64'h0);
        chk({name, "_ctl"}, {fetch_valid, pe_en, pe_finish, busy, done}, 64'h0);
    endtask

    task automatic run_case(input vec_t v, input int idx);
        int    t0, beats, stall_left, exp_lat;
        bit    got_done, poked;
        beat_t e;
        exp_q.delete();
        model_push(v);
        beats = 0; stall_left = v.stall_len; got_done = 0; poked = 0;
        exp_lat = (v.exp_beats == 0) ? 2 : 2 + v.exp_beats + v.stall_len;
        @(negedge clk);
        load_cfg(v);
        start = 1'b1;
        t0 = cyc;
        for (int n = 0; n < 300 && !got_done; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 0) chk($sformatf("v%0d_busy_load", idx), busy, 1);
            if (v.poke_beat != 0 && !poked && fetch_valid && beats + 1 == v.poke_beat) begin
                start = 1'b1;
                poked = 1;
            end
            if (fetch_valid && beats + 1 == v.stall_beat && stall_left > 0) begin
                fetch_ready = 1'b0;
                stall_left--;
            end else begin
                fetch_ready = 1'b1;
            end
            if (fetch_valid) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("v%0d_extra_beat", idx), 1, 0);
                end else begin
                    e = exp_q[0];
                    chk($sformatf("v%0d_b%0d_ifm", idx, beats + 1), addr_ifm, e.ifm);
                    chk($sformatf("v%0d_b%0d_wgt", idx, beats + 1), addr_weight, e.wgt);
                    chk($sformatf("v%0d_b%0d_en", idx, beats + 1), pe_en, e.en);
                    chk($sformatf("v%0d_b%0d_fin", idx, beats + 1), pe_finish, e.fin);
                    if (fetch_ready) begin
                        void'(exp_q.pop_front());
                        beats++;
                        if (beats == v.exp_beats) begin
                            chk($sformatf("v%0d_last_ifm", idx), addr_ifm, v.last_ifm);
                            chk($sformatf("v%0d_last_wgt", idx), addr_weight, v.last_wgt);
                            chk($sformatf("v%0d_last_lanes", idx), {pe_en, pe_finish},
                                {v.last_en, v.last_fin});
                        end
                    end
                end
            end else begin
                chk($sformatf("v%0d_lanes_idle", idx), {pe_en, pe_finish}, 0);
            end
            if (done) begin
                got_done = 1;
                chk($sformatf("v%0d_done_latency", idx), cyc - t0, exp_lat);
                chk($sformatf("v%0d_done_no_valid", idx), fetch_valid, 0);
            end
        end
        start = 1'b0;
        fetch_ready = 1'b1;
        if (!got_done) chk($sformatf("v%0d_done_timeout", idx), 0, 1);
        chk($sformatf("v%0d_beat_count", idx), beats, v.exp_beats);
        chk($sformatf("v%0d_scoreboard_empty", idx), exp_q.size(), 0);
        @(negedge clk);
        chk($sformatf("v%0d_done_one_cycle", idx), {done, busy}, 0);
    endtask

    // Run C=8,F=4,P=2 until beat 3 is presented, then abort or reset
    task automatic run_interrupted(input bit use_reset);
        int  beats;
        bit  hit;
        string tag;
        tag = use_reset ? "rst" : "abort";
        beats = 0; hit = 0;
        @(negedge clk);
        cfg_channels = 16'd8; cfg_filters = 16'd4; cfg_pixels = 16'd2;
        ifm_base = '0; wgt_base = '0;
        start = 1'b1;
        for (int n = 0; n < 50 && !hit; n++) begin
            @(negedge clk);
            start = 1'b0;
            fetch_ready = 1'b1;
            if (fetch_valid) begin
                if (beats == 2) hit = 1;
                else beats++;
            end
        end
        if (!hit) begin
            chk({tag, "_beat3_timeout"}, 0, 1);
        end else begin
            chk({tag, "_beat3_ifm"}, addr_ifm, 32'd8);
            fetch_ready = 1'b0;
            if (use_reset) begin
                reset_n = 1'b0;
                #1;
                check_all_zero({tag, "_async"});
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
            check_all_zero({tag, "_after"});
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                chk({tag, "_quiet"}, {done, fetch_valid, busy}, 0);
            end
        end
        fetch_ready = 1'b1;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = mk(8, 4, 2, 32'h0,   32'h0,   0, 0, 0, 4,  32'd12,  32'd4,   4'b1111, 4'b1111);
        vecs[1] = mk(8, 6, 1, 32'h0,   32'h0,   0, 0, 0, 4,  32'd4,   32'd12,  4'b0011, 4'b0011);
        vecs[2] = mk(6, 4, 1, 32'h100, 32'h200, 0, 0, 0, 2,  32'h104, 32'h204, 4'b1111, 4'b1111);
        vecs[3] = mk(8, 4, 2, 32'h0,   32'h0,   2, 3, 0, 4,  32'd12,  32'd4,   4'b1111, 4'b1111);
        vecs[4] = mk(8, 4, 0, 32'h0,   32'h0,   0, 0, 0, 0,  32'd0,   32'd0,   4'b0000, 4'b0000);
        vecs[5] = mk(8, 4, 2, 32'h0,   32'h0,   0, 0, 2, 4,  32'd12,  32'd4,   4'b1111, 4'b1111);
        vecs[6] = mk(5, 9, 3, 32'hFFFF_FFF0, 32'h40, 0, 0, 0, 18, 32'h4, 32'h54, 4'b0001, 4'b0001);
        vecs[7] = mk(1, 1, 3, 32'h10,  32'h20,  0, 0, 0, 3,  32'h18,  32'h20,  4'b0001, 4'b0001);
        vecs[8] = mk(0, 4, 2, 32'h0,   32'h0,   0, 0, 0, 0,  32'd0,   32'd0,   4'b0000, 4'b0000);
        vecs[9] = mk(8, 0, 2, 32'h0,   32'h0,   0, 0, 0, 0,  32'd0,   32'd0,   4'b0000, 4'b0000);

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // start and abort together in IDLE: abort wins, nothing starts
        load_cfg(vecs[0]);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("start_abort_idle", {busy, fetch_valid, done}, 0);
        end

        for (int i = 0; i < 10; i++) run_case(vecs[i], i);

        run_interrupted(1'b0);
        run_case(vecs[0], 10);
        run_interrupted(1'b1);
        run_case(vecs[0], 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
